bayer_to_gray: RTL and testbench

- Upstream stage of the Sobel edge-detection module.
- Consumes the raw 12-bit Bayer pixel stream from capture and collapses each 2x2 Bayer quad (R, G1, G2, B) into one 12-bit grayscale pixel.
- Outputs the grayscale stream with its own valid strobe and down-scaled coordinates.
- Internally holds one raw row in a line buffer so the upper half of each quad is available when the lower row arrives.

---
 rtl/bayer_to_gray_if.sv | 33 +++
 rtl/bayer_to_gray.sv | 88 ++++++++
 tb/tb_bayer_to_gray.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bayer_to_gray_if.sv
// ============================================================================
// Module  : bayer_to_gray_if
// Brief   : Raw Bayer input stream plus down-scaled grayscale output stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bayer_to_gray_if #(
  parameter int DW = 12
);
  logic [DW-1:0] iDATA;
  logic          iDVAL;
  logic [10:0]   iX_Cont;
  logic [10:0]   iY_Cont;
  logic [DW-1:0] oGray;
  logic          oDVAL;
  logic [10:0]   oX_Cont;
  logic [10:0]   oY_Cont;
  logic          oFrameDone;

  // master drives raw pixels and observes grayscale results
  modport master (
    output iDATA, iDVAL, iX_Cont, iY_Cont,
    input  oGray, oDVAL, oX_Cont, oY_Cont, oFrameDone
  );

  modport slave (
    input  iDATA, iDVAL, iX_Cont, iY_Cont,
    output oGray, oDVAL, oX_Cont, oY_Cont, oFrameDone
  );
endinterface

`default_nettype wire

// File: rtl/bayer_to_gray.sv
// ============================================================================
// Module  : bayer_to_gray
// Brief   : Averages each 2x2 Bayer quad into one grayscale pixel.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bayer_to_gray #(
  parameter int ROW_LENGTH = 1280,
  parameter int ROWS       = 960,
  parameter int DW         = 12
) (
  input  wire logic        iCLK,
  input  wire logic        iRST,
  bayer_to_gray_if.slave   bus
);

  localparam int          c_AW      = (ROW_LENGTH > 1) ? $clog2(ROW_LENGTH) : 1;
  localparam logic [10:0] c_ROW_LEN = 11'(ROW_LENGTH);
  localparam logic [10:0] c_ROWS    = 11'(ROWS);
  localparam logic [10:0] c_LAST_X  = 11'(ROW_LENGTH - 1);
  localparam logic [10:0] c_LAST_Y  = 11'(ROWS - 1);

  logic [DW-1:0]   r_line [ROW_LENGTH];
  logic [DW-1:0]   r_cur_d;
  logic [DW-1:0]   r_prev_d;
  logic [DW-1:0]   r_gray;
  logic            r_dval;
  logic [10:0]     r_x;
  logic [10:0]     r_y;
  logic            r_done;

  logic            w_accept;
  logic            w_complete;
  logic [c_AW-1:0] w_addr;
  logic [DW-1:0]   w_above;
  logic [DW+1:0]   w_sum;

  assign w_accept   = bus.iDVAL && (bus.iX_Cont < c_ROW_LEN) && (bus.iY_Cont < c_ROWS);
  assign w_complete = w_accept && bus.iX_Cont[0] && bus.iY_Cont[0];
  assign w_addr     = bus.iX_Cont[c_AW-1:0];
  // Combinational read sees the previous row's value before this accept overwrites it
  assign w_above    = r_line[w_addr];
  assign w_sum      = {2'b00, r_prev_d} + {2'b00, w_above}
                    + {2'b00, r_cur_d}  + {2'b00, bus.iDATA};

  always_ff @(posedge iCLK) begin
    if (w_accept) begin
      r_line[w_addr] <= bus.iDATA;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_cur_d  <= '0;
      r_prev_d <= '0;
      r_gray   <= '0;
      r_dval   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_done   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cur_d  <= bus.iDATA;
        r_prev_d <= w_above;
      end
      if (w_complete) begin
        r_gray <= DW'(w_sum >> 2);
        r_x    <= {1'b0, bus.iX_Cont[10:1]};
        r_y    <= {1'b0, bus.iY_Cont[10:1]};
        r_dval <= 1'b1;
        r_done <= (bus.iX_Cont == c_LAST_X) && (bus.iY_Cont == c_LAST_Y);
      end else begin
        r_dval <= 1'b0;
        r_done <= 1'b0;
      end
    end
  end

  assign bus.oGray      = r_gray;
  assign bus.oDVAL      = r_dval;
  assign bus.oX_Cont    = r_x;
  assign bus.oY_Cont    = r_y;
  assign bus.oFrameDone = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bayer_to_gray.sv
// ============================================================================
// Module  : tb_bayer_to_gray
// Brief   : Directed, self-checking bench for bayer_to_gray on a 4x4 frame.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bayer_to_gray;

  localparam int RL = 4;
  localparam int RW = 4;
  localparam int DW = 12;

  typedef struct {
    int gray;
    int x;
    int y;
    int done;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   img [RW][RL];
  exp_t q [$];
  int   got [$];

  bayer_to_gray_if #(.DW(DW)) bus ();

  bayer_to_gray #(.ROW_LENGTH(RL), .ROWS(RW), .DW(DW)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pix(input int mode, input int y, input int x);
    int t [RW][RL];
    case (mode)
      1: return 4095;
      2: begin
        t = '{'{1, 1, 3, 3}, '{1, 0, 3, 2}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        return t[y][x];
      end
      3: return y * RL + x + 100;
      default: return y * RL + x;
    endcase
  endfunction

  // Drive one input cycle; accepted quad-completing pixels queue their expected result
  task automatic drive(input int x, input int y, input int d, input bit v);
    exp_t e;
    @(posedge clk);
    #1;
    bus.iDVAL   = v;
    bus.iDATA   = DW'(d);
    bus.iX_Cont = 11'(x);
    bus.iY_Cont = 11'(y);
    if (v && x < RL && y < RW) begin
      img[y][x] = d;
      if ((x % 2 == 1) && (y % 2 == 1)) begin
        e.gray = (img[y-1][x-1] + img[y-1][x] + img[y][x-1] + img[y][x]) / 4;
        e.x    = x / 2;
        e.y    = y / 2;
        e.done = (x == RL - 1 && y == RW - 1) ? 1 : 0;
        e.due  = cyc + 1;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, int'($urandom_range(0, 4095)), 1'b0);
  endtask

  task automatic frame(input int mode, input bit gaps);
    for (int y = 0; y < RW; y++) begin
      for (int x = 0; x < RL; x++) begin
        drive(x, y, pix(mode, y, x), 1'b1);
        if (gaps) begin
          if ((x + y) % 2 == 0)
            drive(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                  int'($urandom_range(0, 4095)), 1'b0);
          else
            drive(int'($urandom_range(RL, 2047)), y, int'($urandom_range(0, 4095)), 1'b1);
        end
      end
    end
  endtask

  task automatic drain(input string name);
    idle(3);
    chk({name, "_pending"}, q.size(), 0);
  endtask

  task automatic basic_lits(input string name, input int off);
    int lit [4];
    lit = '{2, 4, 10, 12};
    chk({name, "_count"}, got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk({name, "_gray"}, got[i], lit[i] + off);
  endtask

  // Compare process: every negedge the DUT outputs are judged against the model queue
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_gray", int'(bus.oGray), 0);
      chk("rst_dval", int'(bus.oDVAL), 0);
      chk("rst_x", int'(bus.oX_Cont), 0);
      chk("rst_y", int'(bus.oY_Cont), 0);
      chk("rst_done", int'(bus.oFrameDone), 0);
    end else if (bus.oDVAL) begin
      if (q.size() == 0) begin
        chk("spurious_dval", 1, 0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc, e.due);
        chk("gray", int'(bus.oGray), e.gray);
        chk("out_x", int'(bus.oX_Cont), e.x);
        chk("out_y", int'(bus.oY_Cont), e.y);
        chk("frame_done", int'(bus.oFrameDone), e.done);
      end
      got.push_back(int'(bus.oGray));
      if (bus.oFrameDone) done_cnt++;
    end else begin
      chk("done_without_dval", int'(bus.oFrameDone), 0);
      if (q.size() != 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("missing_dval", 0, 1);
      end
    end
  end

  initial begin
    bus.iDVAL   = 1'b0;
    bus.iDATA   = '0;
    bus.iX_Cont = '0;
    bus.iY_Cont = '0;
    for (int y = 0; y < RW; y++)
      for (int x = 0; x < RL; x++) img[y][x] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    got.delete();
    frame(0, 1'b0);
    drain("basic");
    basic_lits("basic", 0);

    got.delete();
    frame(1, 1'b0);
    drain("full");
    chk("full_count", got.size(), 4);
    foreach (got[i]) chk("full_gray", got[i], 4095);

    got.delete();
    frame(2, 1'b0);
    drain("trunc");
    chk("trunc_count", got.size(), 4);
    if (got.size() >= 2) begin
      chk("trunc_q0", got[0], 0);
      chk("trunc_q1", got[1], 2);
    end

    got.delete();
    frame(0, 1'b1);
    drain("gaps");
    basic_lits("gaps", 0);

    // Reset lands mid row 1 after quad (0,0) has been reported
    got.delete();
    for (int x = 0; x < RL; x++) drive(x, 0, pix(0, 0, x), 1'b1);
    drive(0, 1, pix(0, 1, 0), 1'b1);
    drive(1, 1, pix(0, 1, 1), 1'b1);
    drive(2, 1, pix(0, 1, 2), 1'b1);
    #6 rst = 1'b1;
    #1;
    chk("async_rst_gray", int'(bus.oGray), 0);
    chk("async_rst_x", int'(bus.oX_Cont), 0);
    chk("async_rst_dval", int'(bus.oDVAL), 0);
    chk("pre_rst_gray", (got.size() > 0) ? got[0] : -1, 2);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.iDVAL = 1'b0;
    got.delete();
    idle(2);
    chk("post_rst_no_dval", got.size(), 0);
    frame(0, 1'b0);
    drain("restart");
    basic_lits("restart", 0);

    got.delete();
    done_cnt = 0;
    frame(0, 1'b0);
    frame(3, 1'b0);
    drain("b2b");
    chk("b2b_count", got.size(), 8);
    chk("b2b_done_pulses", done_cnt, 2);
    if (got.size() == 8)
      for (int i = 0; i < 4; i++) chk("b2b_delta", got[i + 4] - got[i], 100);
    got = got[4:$];
    basic_lits("b2b_second", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
